// File: rtl/vram_arbiter.sv
// vram_arbiter: arbitrates a CPU and a VGA requester onto a single-port synchronous VRAM
//   Parameter MAX_VGA_BURST (1..15): consecutive VGA grants allowed while the CPU waits.
//   clk/reset       : rising-edge clock, asynchronous active-low reset
//   cpu_*           : CPU request (req, write, addr, data_out) and response (data_in, ready, done)
//   vga_*           : VGA read request (req, addr) and response (data, ready)
//   mem_*           : RAM port (en, we, addr, wdata out; rdata in, 1-cycle read latency)
//   stat_*_grants   : grant counters, present only when VRAM_ARBITER_STATS_EN is defined
module vram_arbiter #(
    parameter int MAX_VGA_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [14:0] cpu_addr,
    input  logic [31:0] cpu_data_out,
    output logic [31:0] cpu_data_in,
    output logic        cpu_ready,
    output logic        cpu_done,
    input  logic        vga_req,
    input  logic [14:0] vga_addr,
    output logic [31:0] vga_data,
    output logic        vga_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] stat_cpu_grants,
    output logic [15:0] stat_vga_grants
);
    typedef enum logic [2:0] {IDLE, C_ISSUE, C_CAPT, C_RESP, V_ISSUE, V_CAPT, V_RESP} state_t;
    localparam logic [3:0] MAX_B = 4'(MAX_VGA_BURST);
    state_t      state_q, state_d;
    logic        cpu_armed_q, cpu_armed_d, vga_armed_q, vga_armed_d;
    logic [3:0]  streak_q, streak_d;
    logic        we_q, done_q;
    logic [14:0] addr_q;
    logic [31:0] wdata_q, cdata_q, vdata_q;
    logic        cpu_pend, vga_pend, cpu_grant, vga_grant;
    always_comb begin
        cpu_pend  = cpu_req & cpu_armed_q;
        vga_pend  = vga_req & vga_armed_q;
        cpu_grant = (state_q == IDLE) & cpu_pend & (!vga_pend | (streak_q == MAX_B));
        vga_grant = (state_q == IDLE) & vga_pend & !cpu_grant;
        state_d   = IDLE;
        case (state_q)
            IDLE:    state_d = cpu_grant ? C_ISSUE : vga_grant ? V_ISSUE : IDLE;
            C_ISSUE: state_d = C_CAPT;
            C_CAPT:  state_d = C_RESP;
            V_ISSUE: state_d = V_CAPT;
            V_CAPT:  state_d = V_RESP;
            default: state_d = IDLE;
        endcase
        // A VGA grant can only happen with the CPU pending while streak < MAX, so the cap holds.
        streak_d    = cpu_grant ? 4'd0 : vga_grant ? (cpu_pend ? streak_q + 4'd1 : 4'd0) : streak_q;
        cpu_armed_d = !cpu_req | (cpu_armed_q & !cpu_grant);
        vga_armed_d = !vga_req | (vga_armed_q & !vga_grant);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cpu_armed_q <= 1'b1;
            vga_armed_q <= 1'b1;
            streak_q    <= 4'd0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= 15'd0;
            wdata_q     <= 32'd0;
            cdata_q     <= 32'd0;
            vdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cpu_armed_q <= cpu_armed_d;
            vga_armed_q <= vga_armed_d;
            streak_q    <= streak_d;
            done_q      <= state_q == C_RESP;
            if (cpu_grant) begin
                addr_q  <= cpu_addr;
                we_q    <= cpu_write;
                wdata_q <= cpu_data_out;
            end else if (vga_grant) begin
                addr_q  <= vga_addr;
                we_q    <= 1'b0;
            end
            if (state_q == C_CAPT && !we_q) cdata_q <= mem_rdata;
            if (state_q == V_CAPT) vdata_q <= mem_rdata;
        end
    end
    assign mem_en      = (state_q == C_ISSUE) | (state_q == V_ISSUE);
    assign mem_we      = (state_q == C_ISSUE) & we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign cpu_data_in = cdata_q;
    assign vga_data    = vdata_q;
    assign cpu_ready   = state_q == C_RESP;
    assign vga_ready   = state_q == V_RESP;
    assign cpu_done    = done_q;
`ifdef VRAM_ARBITER_STATS_EN
    logic [15:0] cpu_cnt_q, vga_cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_cnt_q <= 16'd0;
            vga_cnt_q <= 16'd0;
        end else begin
            if (cpu_grant) cpu_cnt_q <= cpu_cnt_q + 16'd1;
            if (vga_grant) vga_cnt_q <= vga_cnt_q + 16'd1;
        end
    end
    assign stat_cpu_grants = cpu_cnt_q;
    assign stat_vga_grants = vga_cnt_q;
`else
    assign stat_cpu_grants = 16'd0;
    assign stat_vga_grants = 16'd0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scoreboard bench for vram_arbiter with a behavioural 1-cycle-latency RAM
module tb_vram_arbiter;
    logic        clk = 1'b0, reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_write = 1'b0, vga_req = 1'b0;
    logic [14:0] cpu_addr = '0, vga_addr = '0;
    logic [31:0] cpu_data_out = '0;
    logic [31:0] cpu_data_in, vga_data, mem_wdata, mem_rdata;
    logic        cpu_ready, cpu_done, vga_ready, mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [15:0] stat_cpu_grants, stat_vga_grants;

    vram_arbiter #(.MAX_VGA_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
        .cpu_data_in(cpu_data_in), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_ready(vga_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stat_cpu_grants(stat_cpu_grants), .stat_vga_grants(stat_vga_grants)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] CPU_WORD = 32'hDEADBEEF;
    localparam logic [31:0] VGA_WORD = 32'hCAFEF00D;

    function automatic logic [31:0] preload(input logic [14:0] a);
        return (a == 15'h1234) ? CPU_WORD : (a == 15'h0100) ? VGA_WORD : {17'd0, a};
    endfunction

    logic [31:0] mem [0:32767];
    bit          wr  [0:32767];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                wr[mem_addr]  <= 1'b1;
            end else begin
                mem_rdata <= wr[mem_addr] ? mem[mem_addr] : preload(mem_addr);
            end
        end
    end

    typedef struct packed {logic cpu; logic [31:0] data;} exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, fails = 0;

    always @(negedge clk) begin
        if (reset && (cpu_ready || vga_ready)) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $error("FAIL sb_underflow: got cpu_ready=%0b vga_ready=%0b expected no response", cpu_ready, vga_ready);
            end else begin
                mon_e = sb.pop_front();
                assert ({cpu_ready, vga_ready, cpu_ready ? cpu_data_in : vga_data} === {mon_e.cpu, !mon_e.cpu, mon_e.data})
                else begin
                    fails++;
                    $error("FAIL response: got cpu=%0b vga=%0b data=%h expected cpu=%0b data=%h",
                           cpu_ready, vga_ready, cpu_ready ? cpu_data_in : vga_data, mon_e.cpu, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {27'd0, mem_en, mem_we, cpu_ready, vga_ready, cpu_done}, 32'd0);
        chk({tag, "_addr"}, {17'd0, mem_addr}, 32'd0);
        chk({tag, "_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cdata"}, cpu_data_in, 32'd0);
        chk({tag, "_vdata"}, vga_data, 32'd0);
        chk({tag, "_stats"}, {stat_cpu_grants, stat_vga_grants}, 32'd0);
    endtask

    task automatic cpu_op(input logic w, input logic [14:0] a, input logic [31:0] d, input logic [31:0] e);
        cpu_write = w; cpu_addr = a; cpu_data_out = d; cpu_req = 1'b1;
        sb.push_back({1'b1, e});
        step();
        chk("c_issue_en", {31'd0, mem_en}, 32'd1);
        chk("c_issue_we", {31'd0, mem_we}, {31'd0, w});
        chk("c_issue_addr", {17'd0, mem_addr}, {17'd0, a});
        if (w) chk("c_issue_wdata", mem_wdata, d);
        cpu_req = 1'b0;
        step();
        chk("c_capt_en_rdy", {30'd0, mem_en, cpu_ready}, 32'd0);
        step();
        chk("c_resp_rdy", {31'd0, cpu_ready}, 32'd1);
        step();
        chk("c_done", {30'd0, cpu_done, cpu_ready}, 32'd2);
        step();
        chk("c_done_clr", {31'd0, cpu_done}, 32'd0);
    endtask

    task automatic vga_op(input logic [14:0] a, input logic [31:0] e);
        vga_addr = a; vga_req = 1'b1;
        sb.push_back({1'b0, e});
        step();
        chk("v_issue_en_we", {30'd0, mem_en, mem_we}, 32'd2);
        chk("v_issue_addr", {17'd0, mem_addr}, {17'd0, a});
        vga_req = 1'b0;
        step();
        chk("v_capt_rdy", {31'd0, vga_ready}, 32'd0);
        step();
        chk("v_resp_rdy", {31'd0, vga_ready}, 32'd1);
        step();
        chk("v_resp_clr", {30'd0, vga_ready, cpu_done}, 32'd0);
    endtask

    initial begin
        int cnt, en_cnt, g, last;
        repeat (2) step();
        chk_zero("reset");
        reset = 1'b1;
        step();
        chk("idle_en", {31'd0, mem_en}, 32'd0);

        cpu_op(1'b0, 15'h1234, 32'd0, CPU_WORD);
        cpu_op(1'b1, 15'h0007, 32'hA5A5A5A5, CPU_WORD);
        cpu_op(1'b0, 15'h0007, 32'd0, 32'hA5A5A5A5);

        cpu_addr = 15'h1234; cpu_write = 1'b0; cpu_req = 1'b1;
        sb.push_back({1'b1, CPU_WORD});
        cnt = 0; en_cnt = 0;
        repeat (20) begin
            step();
            if (cpu_ready) cnt++;
            if (mem_en) en_cnt++;
        end
        cpu_req = 1'b0;
        step();
        chk("held_req_ready_pulses", cnt, 1);
        chk("held_req_accesses", en_cnt, 1);

        for (int i = 0; i < 10; i++) sb.push_back({(i % 5) == 4, ((i % 5) == 4) ? CPU_WORD : VGA_WORD});
        cpu_addr = 15'h1234; vga_addr = 15'h0100; cpu_req = 1'b1; vga_req = 1'b1;
        g = 0; last = -1;
        for (int k = 0; k < 80 && g < 10; k++) begin
            step();
            if (cpu_ready || vga_ready) begin
                if (last >= 0) chk("burst_gap", k - last, 4);
                last = k;
                g++;
            end
            if (g == 10) begin
                cpu_req = 1'b0; vga_req = 1'b0;
            end else begin
                vga_req = !vga_ready; cpu_req = !cpu_ready;
            end
        end
        chk("burst_grants", g, 10);
        repeat (2) step();

        cpu_addr = 15'h1234; cpu_write = 1'b0; cpu_req = 1'b1;
        step();
        chk("abort_issue_en", {31'd0, mem_en}, 32'd1);
        cpu_req = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk_zero("abort");
        cnt = 0;
        repeat (3) begin
            step();
            if (cpu_ready || cpu_done) cnt++;
        end
        chk("abort_no_ready", cnt, 0);
        reset = 1'b1;
        vga_op(15'h0100, VGA_WORD);

        for (int i = 0; i < 3; i++) cpu_op(1'b0, 15'h1234, 32'd0, CPU_WORD);
        for (int i = 0; i < 4; i++) vga_op(15'h0100, VGA_WORD);
`ifdef VRAM_ARBITER_STATS_EN
        chk("stat_cpu", {16'd0, stat_cpu_grants}, 32'd3);
        chk("stat_vga", {16'd0, stat_vga_grants}, 32'd5);
`else
        chk("stat_cpu", {16'd0, stat_cpu_grants}, 32'd0);
        chk("stat_vga", {16'd0, stat_vga_grants}, 32'd0);
`endif
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter MAX_VGA_BURST, default 4: the maximum number of consecutive VGA grants while a CPU request waits (range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have CPU ports cpu_req in 1, cpu_write in 1, cpu_addr in 15, cpu_data_out in 32 (write data), cpu_data_in out 32 (read data), cpu_ready out 1, cpu_done out 1.
REQ-005 SHALL have VGA ports vga_req in 1, vga_addr in 15, vga_data out 32, vga_ready out 1.
REQ-006 SHALL have memory ports mem_en out 1, mem_we out 1, mem_addr out 15, mem_wdata out 32, mem_rdata in 32; the memory is a single-port synchronous RAM with 1-cycle read latency.
REQ-007 SHALL have stat_cpu_grants out 16 and stat_vga_grants out 16.

Function
REQ-008 SHALL implement states IDLE, C_ISSUE, C_CAPT, C_RESP, V_ISSUE, V_CAPT, V_RESP.
REQ-009 SHALL keep per-requester flags cpu_armed and vga_armed: each clears on that requester's grant and sets on any cycle its req is sampled low; a requester is pending when req=1 and armed=1.
REQ-010 SHALL leave IDLE only when a requester is pending; the grant decision is taken at the edge that leaves IDLE.
REQ-011 Arbitration when both requesters are pending: VGA wins, unless vga_streak equals MAX_VGA_BURST, in which case CPU wins.
REQ-012 vga_streak (4 bits) SHALL behave as follows: increment on a VGA grant while CPU is pending; clear on a VGA grant while CPU is not pending; clear on a CPU grant; never exceed MAX_VGA_BURST.
REQ-013 On grant, SHALL latch the address (and for CPU, cpu_write and cpu_data_out) into mem_addr, mem_we and mem_wdata; these registers hold until the next grant.
REQ-014 *_ISSUE state: mem_en=1 and mem_we=latched write (CPU) or 0 (VGA); in every other state, mem_en=0 and mem_we=0.
REQ-015 *_CAPT state: SHALL register mem_rdata into cpu_data_in or vga_data (reads only; CPU writes leave cpu_data_in unchanged).
REQ-016 *_RESP state: the granted requester's ready=1 for exactly one cycle; next state is IDLE.
REQ-017 cpu_done SHALL be 1 for exactly the one cycle following C_RESP; in that cycle, arbitration from IDLE proceeds normally.
REQ-018 Latency: if pending is sampled in IDLE at edge t, ISSUE occupies cycle t+1, ready is high in cycle t+3, and cpu_done in cycle t+4; writes take the same path and latency as reads.
REQ-019 A req held high continuously after ready SHALL NOT cause a second access; req must be sampled low at least once (re-arm) before the next grant.
REQ-020 req deasserted after grant: the access SHALL still complete and ready still pulse.
REQ-021 Back-to-back VGA-CPU-VGA sequences SHALL incur no idle cycle beyond the mandatory IDLE cycle between accesses.

Reset
REQ-022 reset low SHALL immediately force: state=IDLE, cpu_armed=vga_armed=1, vga_streak=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, cpu_data_in=0, vga_data=0, cpu_ready=vga_ready=cpu_done=0, stat counters=0.
REQ-023 Reset asserted mid-access SHALL abort the access with no ready or done pulse; after release, the next grant occurs on the first pending request.

Configuration
REQ-024 Macro VRAM_ARBITER_STATS_EN defined: stat_cpu_grants and stat_vga_grants SHALL count grants to each requester, wrapping 16'hFFFF -> 0.
REQ-025 Macro VRAM_ARBITER_STATS_EN undefined: both stat ports SHALL be tied to 0, no counter logic exists, and all other behaviour is unchanged.

Verification
REQ-026 Case 1: memory preloaded 0x1234 = 32'hDEADBEEF; CPU read of 0x1234 -> mem_en high in cycle t+1, cpu_ready in cycle t+3 with cpu_data_in=32'hDEADBEEF, cpu_done in cycle t+4.
REQ-027 Case 2: CPU write of 32'hA5A5A5A5 to 0x0007, then CPU read of 0x0007 after re-arm -> write cycle shows mem_we=1 and mem_addr=0x0007; the read returns 32'hA5A5A5A5.
REQ-028 Case 3: MAX_VGA_BURST=4; vga_req toggled so it is always pending; cpu_req held -> grant order V,V,V,V,C,V,V,V,V,C.
REQ-029 Case 4: cpu_req held high for 20 cycles with VGA idle -> exactly one CPU access; cpu_ready pulses once.
REQ-030 Case 5: reset asserted during C_CAPT -> all outputs 0 immediately, no cpu_ready; after release, a VGA request completes with standard latency.
REQ-031 Case 6: with VRAM_ARBITER_STATS_EN defined, 3 CPU and 5 VGA accesses -> stat_cpu_grants=3, stat_vga_grants=5; without the macro, both read 0.
